// File: rtl/hart_return_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hart_return_router_pkg
// Brief    : Shared sizing, request-kind encodings and tag type for the
//            per-hart return router.
// Revision : 1.0 - initial release
// ============================================================================
package hart_return_router_pkg;

    localparam int NUM_HARTS   = 5;
    localparam int RSP_LATENCY = 2;
    localparam int HART_W      = 3;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        KIND_ALU   = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10,
        KIND_RSVD  = 2'b11
    } req_kind_e;

    typedef struct packed {
        logic              valid;
        logic [HART_W-1:0] hart;
        req_kind_e         kind;
    } tag_t;

    function automatic logic is_bad_req(input logic [HART_W-1:0] hart, input req_kind_e kind);
        return (hart >= HART_W'(NUM_HARTS)) || (kind == KIND_RSVD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hart_return_router_if.sv
`default_nettype none
// ============================================================================
// Module   : hart_return_router_if
// Brief    : Request/return bundle between the issuing datapath and the
//            per-hart result buffers.
// Revision : 1.0 - initial release
// ============================================================================
interface hart_return_router_if;
    import hart_return_router_pkg::*;

    logic                          req_valid;
    logic [HART_W-1:0]             req_hart;
    logic [1:0]                    req_kind;
    logic [DATA_W-1:0]             alu_result;
    logic [DATA_W-1:0]             mem_rd_data;
    logic [NUM_HARTS-1:0]          rsp_ready;
    logic [NUM_HARTS-1:0]          rsp_valid;
    logic [NUM_HARTS*DATA_W-1:0]   rsp_data;
    logic [NUM_HARTS-1:0]          busy;
    logic [NUM_HARTS-1:0]          err_overflow;
    logic                          err_bad_req;

    modport master (
        output req_valid, req_hart, req_kind, alu_result, mem_rd_data, rsp_ready,
        input  rsp_valid, rsp_data, busy, err_overflow, err_bad_req
    );

    modport slave (
        input  req_valid, req_hart, req_kind, alu_result, mem_rd_data, rsp_ready,
        output rsp_valid, rsp_data, busy, err_overflow, err_bad_req
    );

endinterface
`default_nettype wire

// File: rtl/hart_rsp_slot.sv
`default_nettype none
// ============================================================================
// Module   : hart_rsp_slot
// Brief    : One hart's result buffer, valid/overflow flags and in-flight count.
// Revision : 1.0 - initial release
// ============================================================================
module hart_rsp_slot
    import hart_return_router_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_accept,
    input  wire logic              i_ret,
    input  wire logic [DATA_W-1:0] i_ret_data,
    input  wire logic              i_ready,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_overflow,
    output logic                   o_busy
);

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              overflow_q, overflow_d;
    logic [1:0]        inflight_q, inflight_d;

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        inflight_d = inflight_q;

        // A consume on the return edge frees the buffer for the new result.
        if (i_ret) begin
            if (!valid_q || i_ready) begin
                valid_d = 1'b1;
                data_d  = i_ret_data;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        case ({i_accept, i_ret})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            inflight_q <= 2'd0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            inflight_q <= inflight_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_overflow = overflow_q;
    assign o_busy     = (inflight_q != 2'd0) | valid_q;

endmodule
`default_nettype wire

// File: rtl/hart_return_router.sv
`default_nettype none
// ============================================================================
// Module   : hart_return_router
// Brief    : Fixed-latency tag pipeline steering shared-datapath results back
//            into per-hart result buffers.
// Revision : 1.0 - initial release
// ============================================================================
module hart_return_router
    import hart_return_router_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    hart_return_router_if.slave bus
);

    tag_t                 tag_q [RSP_LATENCY];
    tag_t                 tag_d [RSP_LATENCY];
    logic                 err_bad_req_q, err_bad_req_d;

    req_kind_e            w_req_kind;
    logic                 w_req_bad;
    tag_t                 w_ret_tag;
    logic [DATA_W-1:0]    w_ret_data;
    logic [NUM_HARTS-1:0] w_accept;
    logic [NUM_HARTS-1:0] w_ret;

    always_comb begin
        w_req_kind    = req_kind_e'(bus.req_kind);
        w_req_bad     = is_bad_req(bus.req_hart, w_req_kind);
        tag_d[0]      = '{valid: bus.req_valid & ~w_req_bad, hart: bus.req_hart, kind: w_req_kind};
        for (int s = 1; s < RSP_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        err_bad_req_d = err_bad_req_q | (bus.req_valid & w_req_bad);
    end

    // The last pipeline stage is the return slot; data is sampled this cycle.
    always_comb begin
        w_ret_tag = tag_q[RSP_LATENCY-1];
        case (w_ret_tag.kind)
            KIND_ALU:  w_ret_data = bus.alu_result;
            KIND_LOAD: w_ret_data = bus.mem_rd_data;
            default:   w_ret_data = '0;
        endcase
        w_accept = '0;
        w_ret    = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_accept[h] = tag_d[0].valid  && (tag_d[0].hart  == HART_W'(h));
            w_ret[h]    = w_ret_tag.valid && (w_ret_tag.hart == HART_W'(h));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RSP_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
            err_bad_req_q <= 1'b0;
        end else begin
            for (int s = 0; s < RSP_LATENCY; s++) begin
                tag_q[s] <= tag_d[s];
            end
            err_bad_req_q <= err_bad_req_d;
        end
    end

    generate
        for (genvar h = 0; h < NUM_HARTS; h++) begin : g_slot
            hart_rsp_slot u_slot (
                .clk        (clk),
                .rst        (rst),
                .i_accept   (w_accept[h]),
                .i_ret      (w_ret[h]),
                .i_ret_data (w_ret_data),
                .i_ready    (bus.rsp_ready[h]),
                .o_valid    (bus.rsp_valid[h]),
                .o_data     (bus.rsp_data[h*DATA_W +: DATA_W]),
                .o_overflow (bus.err_overflow[h]),
                .o_busy     (bus.busy[h])
            );
        end
    endgenerate

    assign bus.err_bad_req = err_bad_req_q;

endmodule
`default_nettype wire

// File: doc/hart_return_router.md
HART_RETURN_ROUTER -- requirements
Module: hart_return_router

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 req_valid  in  1  a shared-datapath request was issued this cycle.
REQ-004 req_hart  in  3  issuing hart index, valid range 0-4.
REQ-005 req_kind  in  2  00 ALU, 01 load, 10 store, 11 reserved.
REQ-006 alu_result  in  32  shared datapath result, sampled at return cycle.
REQ-007 mem_rd_data  in  32  shared memory read data, sampled at return cycle.
REQ-008 rsp_ready  in  5  per-hart consume strobe; bit h belongs to hart h.
REQ-009 rsp_valid  out  5  per-hart result buffer holds a result.
REQ-010 rsp_data  out  160  per-hart result; hart h at bits [32h+31:32h].
REQ-011 busy  out  5  hart h has a request in flight or an unconsumed result.
REQ-012 err_overflow  out  5  sticky; a return hit a full buffer for hart h.
REQ-013 err_bad_req  out  1  sticky; req_hart>4 or req_kind=11 accepted on req_valid.

Function
REQ-014 Return latency SHALL be fixed at 2 cycles: a request accepted at edge t returns at edge t+2.
REQ-015 Tag pipeline SHALL be 2 stages of {valid, hart, kind}; stage 2 is the return slot.
REQ-016 Return data SHALL be selected by kind: ALU -> alu_result, load -> mem_rd_data, store -> 32'h0.
REQ-017 A return for hart h SHALL write buffer h and set rsp_valid[h] on the return edge.
REQ-018 Buffer h SHALL clear rsp_valid[h] on an edge where rsp_valid[h]=1 and rsp_ready[h]=1.
REQ-019 A return and a consume for the same hart on the same edge SHALL leave rsp_valid[h]=1 with the new data.
REQ-020 A return to a full, non-consumed buffer SHALL drop the new data, keep the old data, and set err_overflow[h].
REQ-021 rsp_ready[h] while rsp_valid[h]=0 SHALL have no effect.
REQ-022 A request with req_hart>4 or req_kind=11 SHALL not enter the tag pipeline and SHALL set err_bad_req.
REQ-023 Each hart SHALL keep a 2-bit in-flight count: +1 on accept, -1 on return, unchanged when both occur on the same edge.
REQ-024 busy[h] SHALL equal (inflight[h]!=0) | rsp_valid[h], and SHALL be combinational from registered state.
REQ-025 Back-to-back requests from different harts on consecutive cycles SHALL each return in order without loss.

Reset
REQ-026 While rst=1 the block SHALL clear the tag pipeline, in-flight counts, rsp_valid, rsp_data (0), err_overflow and err_bad_req.
REQ-027 Requests in flight when rst asserts SHALL be discarded; none returns after rst deasserts.
REQ-028 req_valid sampled while rst=1 SHALL be ignored.

Structure
REQ-029 Shared package SHALL hold NUM_HARTS=5, RSP_LATENCY=2, and the req_kind encodings KIND_ALU, KIND_LOAD, KIND_STORE, KIND_RSVD.
REQ-030 One sub-module, hart_rsp_slot, SHALL implement a single hart's buffer, valid flag, overflow flag and in-flight count; it SHALL be instantiated NUM_HARTS times.
REQ-031 The top level SHALL hold only the tag pipeline, the kind-based data mux, return decode and err_bad_req.

Verification
REQ-032 ALU request, hart 2, at cycle 5 with alu_result=32'hDEADBEEF at cycle 7 -> rsp_valid[2]=1 after edge 7, rsp_data[95:64]=DEADBEEF, busy[2]=1 from cycle 5 until consumed.
REQ-033 Load for hart 0 and hart 4 on consecutive cycles with mem_rd_data 32'h11 then 32'h44 -> buffers 0 and 4 hold 11 and 44, no error flags.
REQ-034 Two ALU requests for hart 1 with no consume -> first result kept, err_overflow[1]=1; consume on the second return edge instead -> second result held, no error.
REQ-035 req_hart=3'd6 or req_kind=2'b11 -> err_bad_req=1, no rsp_valid change two cycles later.
REQ-036 rst pulsed one cycle after a store request for hart 3 -> after reset rsp_valid=0, busy=0, and no response appears at the original return cycle.
